// File: rtl/updn_counter_ctl.sv
// updn_counter_ctl: parametrised up/down counter controller with
// programmable limit, synchronous load, halt/wrap/saturate boundary modes.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   act        - count enable
//   up_dwn_n   - direction, 1 = up, 0 = down
//   mode       - boundary mode: 00 halt, 01 wrap, 10 saturate, 11 halt
//   limit      - upper terminal value (lower terminal is always 0)
//   load       - synchronous load request
//   load_val   - value applied on load, clipped to limit
//   clr_fault  - clears sticky flags, leaves FAULT
//   count      - registered counter value
//   ovflw      - sticky up-boundary flag
//   unflw      - sticky down-boundary flag
//   tc         - one-cycle pulse per wrap event
//   fault      - high while in FAULT

module updn_counter_ctl #(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     act,
    input  logic                     up_dwn_n,
    input  logic [1:0]               mode,
    input  logic [COUNTER_WIDTH-1:0] limit,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_val,
    input  logic                     clr_fault,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     ovflw,
    output logic                     unflw,
    output logic                     tc,
    output logic                     fault
);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_CNTUP = 4'b0010;
    localparam logic [3:0] S_CNTDN = 4'b0100;
    localparam logic [3:0] S_FAULT = 4'b1000;

    localparam logic [1:0] M_HALT = 2'b00;
    localparam logic [1:0] M_WRAP = 2'b01;
    localparam logic [1:0] M_SAT  = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;

    logic [3:0]               state;
    logic [3:0]               state_nx;
    logic [COUNTER_WIDTH-1:0] count_nx;
    logic [COUNTER_WIDTH-1:0] load_clip;
    logic                     ovflw_nx;
    logic                     unflw_nx;
    logic                     tc_nx;

    logic st_idle;
    logic st_up;
    logic st_dn;
    logic st_flt;
    logic st_run;
    logic mode_wrap;
    logic mode_sat;
    logic mode_halt;
    logic up_evt;
    logic dn_evt;
    logic halt_evt;
    logic ld_go;

    // Exact-match decode: any illegal encoding matches none of these.
    assign st_idle = (state == S_IDLE);
    assign st_up   = (state == S_CNTUP);
    assign st_dn   = (state == S_CNTDN);
    assign st_flt  = (state == S_FAULT);
    assign st_run  = st_idle | st_up | st_dn;

    assign mode_wrap = (mode == M_WRAP);
    assign mode_sat  = (mode == M_SAT);
    assign mode_halt = (mode == M_HALT) | (mode == M_RSVD);

    // >= so a limit lowered below count mid-run still hits the boundary.
    assign up_evt   = st_up & (count >= limit);
    assign dn_evt   = st_dn & (count == '0);
    assign halt_evt = (up_evt | dn_evt) & mode_halt;

    // Load is honoured only in a legal non-FAULT state.
    assign ld_go     = load & st_run;
    assign load_clip = (load_val > limit) ? limit : load_val;

    always_comb begin
        state_nx = S_IDLE;
        unique case (1'b1)
            st_flt: begin
                state_nx = clr_fault ? S_IDLE : S_FAULT;
            end
            st_idle, st_up, st_dn: begin
                if (load)
                    state_nx = S_IDLE;
                else if (halt_evt)
                    state_nx = S_FAULT;
                else if (!act)
                    state_nx = S_IDLE;
                else if (up_dwn_n)
                    state_nx = S_CNTUP;
                else
                    state_nx = S_CNTDN;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Halt mode holds count at the boundary; saturate at 0 is also a hold.
    always_comb begin
        count_nx = count;
        if (ld_go) begin
            count_nx = load_clip;
        end else if (up_evt) begin
            if (mode_wrap)
                count_nx = '0;
            else if (mode_sat)
                count_nx = limit;
        end else if (st_up) begin
            count_nx = count + 1'b1;
        end else if (dn_evt) begin
            if (mode_wrap)
                count_nx = limit;
        end else if (st_dn) begin
            count_nx = count - 1'b1;
        end
    end

    // Clear first, then set: a boundary event beats clr_fault in the
    // same cycle, while load suppresses the event altogether.
    always_comb begin
        ovflw_nx = ovflw;
        unflw_nx = unflw;
        if (clr_fault) begin
            ovflw_nx = 1'b0;
            unflw_nx = 1'b0;
        end
        if (ld_go) begin
            ovflw_nx = 1'b0;
            unflw_nx = 1'b0;
        end else begin
            if (up_evt)
                ovflw_nx = 1'b1;
            if (dn_evt)
                unflw_nx = 1'b1;
        end
    end

    assign tc_nx = ~ld_go & (up_evt | dn_evt) & mode_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            ovflw <= 1'b0;
            unflw <= 1'b0;
            tc    <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            ovflw <= ovflw_nx;
            unflw <= unflw_nx;
            tc    <= tc_nx;
            fault <= (state_nx == S_FAULT);
        end
    end

endmodule
